// File: rtl/pool_rd_sched.sv
// Psum readout sequencer: walks every PEB/address of the PE array, captures the
// 1-cycle-latency read data into a 2-entry buffer and streams it to the pooling unit.
module pool_rd_sched #(
  parameter  int NUMPEB  = 16,
  parameter  int LENPSUM = 16,
  parameter  int DAT_W   = 256,
  localparam int AW      = (LENPSUM > 1) ? $clog2(LENPSUM) : 1,
  localparam int PW      = (NUMPEB > 1) ? $clog2(NUMPEB) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Start,
  output logic              Busy,
  output logic              Done,
  output logic [NUMPEB-1:0] POOLPEB_EnRd,
  output logic [AW-1:0]     POOLPEB_AddrRd,
  input  logic [DAT_W-1:0]  PELPOOL_Dat,
  output logic              POOL_Val,
  input  logic              POOL_Rdy,
  output logic [DAT_W-1:0]  POOL_Dat,
  output logic [PW-1:0]     POOL_PebIdx,
  output logic              POOL_Last
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   peb_q, peb_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            inflight_q;
  logic [PW-1:0]   tag_peb_q;
  logic            tag_last_q;

  logic [1:0]      occ_q, occ_d;
  logic            wr_ptr_q, rd_ptr_q;
  logic [DAT_W-1:0] buf_dat_q  [2];
  logic [PW-1:0]   buf_peb_q  [2];
  logic            buf_last_q [2];

  logic            push, pop, issue, last_issue;
  logic            addr_wrap, peb_end;
  logic [2:0]      pend;

  assign pop  = (occ_q != 2'd0) && POOL_Rdy;
  assign push = inflight_q;

  // Credit check: words already buffered plus the one in flight, less the one
  // leaving this cycle, must leave room for the read issued now.
  assign pend       = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
  assign issue      = (state_q == S_RUN) && (pend < 3'd2);
  assign addr_wrap  = (addr_q == AW'(LENPSUM - 1));
  assign peb_end    = (peb_q == PW'(NUMPEB - 1));
  assign last_issue = issue && addr_wrap && peb_end;

  assign occ_d = occ_q + {1'b0, push} - {1'b0, pop};

  always_comb begin
    state_d = state_q;
    peb_d   = peb_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        peb_d  = '0;
        addr_d = '0;
        if (Start) state_d = S_RUN;
      end
      S_RUN: begin
        if (issue) begin
          if (addr_wrap) begin
            addr_d = '0;
            peb_d  = peb_end ? '0 : peb_q + PW'(1);
          end else begin
            addr_d = addr_q + AW'(1);
          end
          if (last_issue) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (occ_d == 2'd0) state_d = S_DONE;
      end
      S_DONE: begin
        peb_d   = '0;
        addr_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      peb_q      <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      peb_q      <= peb_d;
      addr_q     <= addr_d;
      inflight_q <= issue;
      occ_q      <= occ_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Read-data capture: tag travels with the request, data lands one cycle later
  always_ff @(posedge clk) begin
    if (issue) begin
      tag_peb_q  <= peb_q;
      tag_last_q <= last_issue;
    end
    if (push) begin
      buf_dat_q[wr_ptr_q]  <= PELPOOL_Dat;
      buf_peb_q[wr_ptr_q]  <= tag_peb_q;
      buf_last_q[wr_ptr_q] <= tag_last_q;
    end
  end

  assign POOLPEB_EnRd   = issue ? (NUMPEB'(1) << peb_q) : '0;
  assign POOLPEB_AddrRd = addr_q;

  assign Busy = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign Done = (state_q == S_DONE);

  assign POOL_Val    = (occ_q != 2'd0);
  assign POOL_Dat    = buf_dat_q[rd_ptr_q];
  assign POOL_PebIdx = buf_peb_q[rd_ptr_q];
  assign POOL_Last   = buf_last_q[rd_ptr_q];

endmodule
